// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, timing constants and bit-period helper
package uart_pkg;

  localparam int OVERSAMPLE = 8;
  localparam int PRESCALE_W = 16;
  localparam int COUNTER_W  = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // One bit period in clk cycles; a prescale of 0 is treated as 1.
  function automatic logic [COUNTER_W-1:0] bit_period(input logic [PRESCALE_W-1:0] prescale);
    logic [COUNTER_W-1:0] w_ps;
    w_ps = (prescale == '0) ? COUNTER_W'(1) : COUNTER_W'(prescale);
    return w_ps * COUNTER_W'(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-flop synchronizer for an asynchronous input, resets to 1
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain; reset to line-idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with AXI4-Stream-style one-entry output register
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] output_axi_tdata,
  output logic                  output_axi_tvalid,
  input  logic                  output_axi_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [PRESCALE_W-1:0] prescale
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int SYNC_STAGES = 2;

  logic                  w_rxd;
  logic [COUNTER_W-1:0]  w_new_period;
  logic                  w_tick;

  uart_state_t           r_state;
  logic [COUNTER_W-1:0]  r_counter;
  logic [COUNTER_W-1:0]  r_period;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  r_frame;
  logic                  r_armed;
  logic [1:0]            r_warm;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (rxd),
    .o_sync  (w_rxd)
  );

  assign w_new_period = bit_period(prescale);
  assign w_tick       = (r_counter == '0);

  // Frame receiver: arming, start detection, mid-bit sampling, output register and error pulses.
  // The synchronizer resets to idle-high, so its output is only trusted for arming once it
  // has been flushed with real samples; otherwise a line held low across reset would arm falsely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_counter <= '0;
      r_period  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_frame   <= 1'b0;
      r_armed   <= 1'b0;
      r_warm    <= '0;
    end else begin
      r_overrun <= 1'b0;
      r_frame   <= 1'b0;
      if (r_tvalid && output_axi_tready) begin
        r_tvalid <= 1'b0;
      end
      if (r_warm != 2'(SYNC_STAGES)) begin
        r_warm <= r_warm + 2'd1;
      end else if (w_rxd) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (!w_rxd && r_armed) begin
            r_state   <= START;
            r_busy    <= 1'b1;
            r_period  <= w_new_period;
            r_counter <= (w_new_period >> 1) - COUNTER_W'(1);
          end
        end
        START: begin
          if (!w_tick) begin
            r_counter <= r_counter - COUNTER_W'(1);
          end else if (w_rxd) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= DATA;
            r_bit_cnt <= BIT_CNT_W'(DATA_WIDTH);
            r_counter <= r_period - COUNTER_W'(1);
          end
        end
        DATA: begin
          if (!w_tick) begin
            r_counter <= r_counter - COUNTER_W'(1);
          end else begin
            r_shift   <= (r_shift >> 1) | (DATA_WIDTH'(w_rxd) << (DATA_WIDTH - 1));
            r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
            r_counter <= r_period - COUNTER_W'(1);
            if (r_bit_cnt == BIT_CNT_W'(1)) begin
              r_state <= STOP;
            end
          end
        end
        STOP: begin
          if (!w_tick) begin
            r_counter <= r_counter - COUNTER_W'(1);
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (w_rxd) begin
              r_tdata   <= r_shift;
              r_tvalid  <= 1'b1;
              r_overrun <= r_tvalid && !output_axi_tready;
            end else begin
              // Break condition: stay disarmed until the line returns high.
              r_frame <= 1'b1;
              r_armed <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign output_axi_tdata  = r_tdata;
  assign output_axi_tvalid = r_tvalid;
  assign busy              = r_busy;
  assign overrun_error     = r_overrun;
  assign frame_error       = r_frame;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DW = 8;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready   = 1'b0;
  logic          rxd      = 1'b1;
  logic          busy;
  logic          ovr;
  logic          ferr;
  logic [15:0]   prescale = 16'd1;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .output_axi_tdata  (tdata),
    .output_axi_tvalid (tvalid),
    .output_axi_tready (tready),
    .rxd               (rxd),
    .busy              (busy),
    .overrun_error     (ovr),
    .frame_error       (ferr),
    .prescale          (prescale)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            bad;
    logic [DW-1:0] data;
  } comp_t;

  comp_t         sched[$];
  logic [DW-1:0] delivered[$];
  int            cyc = 0;
  logic          tready_q = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            busy_from = -1;
  int            busy_to = -2;
  int            busy_cnt = 0;
  int            n_fe = 0;
  int            n_ov = 0;
  int            last_rise_cyc = 0;
  logic [DW-1:0] last_rise_data = '0;
  logic          tvalid_prev = 1'b0;
  int            tready_mode = 1;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    tready_q <= tready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int period_of(input logic [15:0] ps);
    return ((ps == 16'd0) ? 1 : int'(ps)) * 8;
  endfunction

  // tready driver: 0 hold low, 1 hold high, 2 random
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tready_mode == 2) tready = 1'($urandom_range(0, 1));
      else tready = (tready_mode == 1);
    end
  end

  // Frame-level model and per-cycle compare
  initial begin
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            exp_fe, exp_ov, exp_busy;
    m_valid = 1'b0;
    m_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_data  = '0;
        sched.delete();
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_error", 32'(ferr), 32'd0);
        chk("rst_overrun", 32'(ovr), 32'd0);
      end else begin
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        if (sched.size() > 0 && sched[0].cyc == cyc) begin
          if (sched[0].bad) begin
            exp_fe = 1'b1;
            if (m_valid && tready_q) m_valid = 1'b0;
          end else begin
            exp_ov  = m_valid && !tready_q;
            m_valid = 1'b1;
            m_data  = sched[0].data;
          end
          void'(sched.pop_front());
        end else if (m_valid && tready_q) begin
          m_valid = 1'b0;
        end
        exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
        chk("tvalid", 32'(tvalid), 32'(m_valid));
        chk("tdata", 32'(tdata), 32'(m_data));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("frame_error", 32'(ferr), 32'(exp_fe));
        chk("overrun_error", 32'(ovr), 32'(exp_ov));
      end
      if (busy) busy_cnt++;
      if (ferr) n_fe++;
      if (ovr) n_ov++;
      if (tvalid && !tvalid_prev) begin
        last_rise_cyc  = cyc;
        last_rise_data = tdata;
      end
      tvalid_prev = tvalid;
      if (tvalid && tready) delivered.push_back(tdata);
    end
  end

  task automatic send_frame(input logic [DW-1:0] data, input bit stop_ok,
                            input logic [15:0] ps, input bit jitter_ps, output int e0);
    int    p;
    comp_t c;
    p = period_of(ps);
    @(posedge clk);
    #1;
    e0       = cyc;
    prescale = ps;
    c.cyc    = e0 + 3 + p / 2 + (DW + 1) * p;
    c.bad    = !stop_ok;
    c.data   = data;
    sched.push_back(c);
    busy_from = e0 + 3;
    busy_to   = e0 + 2 + p / 2 + (DW + 1) * p;
    for (int j = 0; j < DW + 2; j++) begin
      if (j == 0) rxd = 1'b0;
      else if (j <= DW) rxd = data[j-1];
      else rxd = stop_ok;
      tick(p);
      if (j == 1 && jitter_ps) prescale = 16'($urandom_range(0, 9));
    end
  endtask

  task automatic glitch(input logic [15:0] ps, input int len);
    int p;
    p = period_of(ps);
    @(posedge clk);
    #1;
    prescale  = ps;
    rxd       = 1'b0;
    busy_from = cyc + 3;
    busy_to   = cyc + 2 + p / 2;
    tick(len);
    rxd = 1'b1;
    tick(2 * p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            e0, b0, fe0, ov0, p, r;
    logic [15:0]   ps;
    rst_n = 1'b0;
    rxd   = 1'b1;
    tready_mode = 1;
    tick(4);
    chk("reset_tvalid", 32'(tvalid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tdata", 32'(tdata), 32'd0);
    rst_n = 1'b1;
    tick(6);

    // Single frame at P=8
    b0 = busy_cnt; fe0 = n_fe; ov0 = n_ov;
    send_frame(8'hA5, 1'b1, 16'd1, 1'b0, e0);
    tick(4);
    chk("t1_latency", 32'(last_rise_cyc - e0), 32'd79);
    chk("t1_data", 32'(last_rise_data), 32'hA5);
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd76);
    chk("t1_no_errors", 32'((n_fe - fe0) + (n_ov - ov0)), 32'd0);

    // Overrun with consumer stalled
    tready_mode = 0;
    tick(2);
    ov0 = n_ov;
    send_frame(8'h3C, 1'b1, 16'd1, 1'b0, e0);
    send_frame(8'hC3, 1'b1, 16'd1, 1'b0, e0);
    tick(2);
    chk("t2_overrun_count", 32'(n_ov - ov0), 32'd1);
    chk("t2_tdata", 32'(tdata), 32'hC3);
    chk("t2_tvalid_held", 32'(tvalid), 32'd1);
    tready_mode = 1;
    tick(1);
    chk("t2_tvalid_drop", 32'(tvalid), 32'd0);

    // Frame error with a break, then recovery
    fe0 = n_fe;
    send_frame(8'h55, 1'b0, 16'd2, 1'b0, e0);
    tick(12 * 16);
    rxd = 1'b1;
    tick(32);
    chk("t3_frame_error_count", 32'(n_fe - fe0), 32'd1);
    chk("t3_no_word", 32'(tvalid), 32'd0);
    send_frame(8'h5A, 1'b1, 16'd2, 1'b0, e0);
    tick(4);
    chk("t3_recovered", 32'(last_rise_data), 32'h5A);

    // Start-bit glitch
    glitch(16'd1, 3);
    chk("t4_glitch_idle", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b1, 16'd1, 1'b0, e0);
    tick(4);
    chk("t4_data", 32'(last_rise_data), 32'h81);

    // Reset during DATA with the line low at release
    tready_mode = 0;
    send_frame(8'h42, 1'b1, 16'd1, 1'b0, e0);
    tick(4);
    chk("t5_pending", 32'(tvalid), 32'd1);
    fe0 = n_fe; ov0 = n_ov;
    tick(1);
    rxd = 1'b0;
    busy_from = cyc + 3;
    busy_to   = cyc + 1000;
    tick(8);
    rxd = 1'b1;
    tick(20);
    rst_n   = 1'b0;
    busy_to = -2;
    rxd     = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(96);
    rxd = 1'b1;
    tick(16);
    chk("t5_no_flags", 32'((n_fe - fe0) + (n_ov - ov0)), 32'd0);
    chk("t5_no_word", 32'(tvalid), 32'd0);
    tready_mode = 1;
    send_frame(8'h12, 1'b1, 16'd1, 1'b0, e0);
    tick(4);
    chk("t5_data", 32'(last_rise_data), 32'h12);

    // Back-to-back at P=32, then prescale 0
    delivered.delete();
    fe0 = n_fe; ov0 = n_ov;
    send_frame(8'h00, 1'b1, 16'd4, 1'b0, e0);
    send_frame(8'hFF, 1'b1, 16'd4, 1'b0, e0);
    send_frame(8'h7E, 1'b1, 16'd4, 1'b0, e0);
    tick(4);
    chk("t6_count", 32'(delivered.size()), 32'd3);
    if (delivered.size() == 3) begin
      chk("t6_word0", 32'(delivered[0]), 32'h00);
      chk("t6_word1", 32'(delivered[1]), 32'hFF);
      chk("t6_word2", 32'(delivered[2]), 32'h7E);
    end
    chk("t6_no_errors", 32'((n_fe - fe0) + (n_ov - ov0)), 32'd0);
    b0 = busy_cnt;
    send_frame(8'hA5, 1'b1, 16'd0, 1'b0, e0);
    tick(4);
    chk("t6_ps0_latency", 32'(last_rise_cyc - e0), 32'd79);
    chk("t6_ps0_busy_cycles", 32'(busy_cnt - b0), 32'd76);
    chk("t6_ps0_data", 32'(last_rise_data), 32'hA5);

    // Randomized traffic
    tready_mode = 2;
    for (int k = 0; k < 30; k++) begin
      ps = 16'($urandom_range(0, 3));
      p  = period_of(ps);
      r  = $urandom_range(0, 9);
      if (r == 0) begin
        glitch(ps, $urandom_range(1, p / 2));
      end else begin
        send_frame(8'($urandom), r != 1, ps, 1'b1, e0);
        if (r == 1) begin
          tick(p);
          rxd = 1'b1;
          tick(p);
        end
      end
      tick($urandom_range(0, 3));
    end
    tready_mode = 1;
    tick(8);
    chk("final_sched_empty", 32'(sched.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
